eth_header_parser: RTL and testbench
====================================

Name: eth_header_parser

Overview:
Parametrised Ethernet II header parser for the RX path, downstream of the preamble/SFD stripper and upstream of the ARP/IPv4 handlers. It consumes an 8-bit AXI-Stream frame starting at the destination-MAC MSB and captures dst/src MAC and EtherType. It filters on destination MAC (local / broadcast / multicast / promiscuous) and on a programmable EtherType table of NUM_TYPES entries. It publishes a header sideband record, forwards the payload of accepted frames and discards rejected ones.

Parameters:
NUM_TYPES, 2, number of EtherType table entries (1..8)
CNT_W, 16, width of saturating drop counter
IDX_W, derived, max(1, $clog2(NUM_TYPES)); localparam, not overridable

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_tdata  in  8  frame byte, network order
s_tvalid  in  1  input byte valid
s_tready  out  1  input accept
s_tlast  in  1  last byte of frame
m_tdata  out  8  payload byte
m_tvalid  out  1  payload valid
m_tready  in  1  payload accept
m_tlast  out  1  last payload byte
local_mac  in  48  station MAC
type_table  in  16*NUM_TYPES  EtherTypes; entry i at [16*i+15 -: 16]
type_enable  in  NUM_TYPES  per-entry enable
promisc_en  in  1  accept any dst MAC
mcast_en  in  1  accept dst with I/G bit (dst[40]) set
hdr_valid  out  1  one-cycle pulse: header of accepted frame
hdr_dst_mac  out  48  captured dst MAC
hdr_src_mac  out  48  captured src MAC
hdr_type  out  16  captured EtherType
hdr_type_idx  out  IDX_W  matched table index
hdr_vlan_id  out  12  VLAN ID (0 if untagged or feature off)
err_runt  out  1  one-cycle pulse: tlast inside header
drop_count  out  CNT_W  rejected + runt frames, saturating

Behaviour:
- Reset (aresetn=0 at posedge aclk): state SYNC; m_tvalid, m_tlast, hdr_valid, err_runt, drop_count = 0; hdr_* = 0.
- A byte is transferred when s_tvalid && s_tready. Counters advance only on transfers.
- States and transitions:
  - SYNC: s_tready=1; discard until a transfer with s_tlast, then IDLE. Gives realignment after a mid-frame reset.
  - IDLE: first transfer goes to DST byte 0.
  - DST: 6 bytes.
  - SRC: 6 bytes.
  - TYPE: 2 bytes.
  - PAYLOAD, DROP.
- In header states s_tready=1.
- Decision on the transfer of the 2nd type byte:
  - mac_ok = promisc_en | dst==local_mac | dst==FF:FF:FF:FF:FF:FF | (mcast_en & dst[40]).
  - type_hit = any i with type_enable[i] && type_table[i]=={b0,b1}. Lowest i wins.
  - Config is sampled at this cycle.
  - Accept: go to PAYLOAD; next cycle hdr_valid=1 with all hdr_* updated.
  - Reject: go to DROP; drop_count+1.
- hdr_* hold until the next hdr_valid.
- s_tlast on any header byte, including the 2nd type byte: err_runt pulse next cycle, drop_count+1, go to IDLE, no hdr_valid.
- PAYLOAD uses a single output register, latency 1.
  - s_tready = !m_tvalid || m_tready.
  - A transfer with s_tlast sets m_tlast and goes to IDLE. m_tvalid drains independently of state.
  - IDLE must not start a new frame's DST bytes while a prior m_tvalid is stalled. Header bytes are not forwarded, so IDLE/header states still accept.
- DROP: s_tready=1; on tlast transfer go to IDLE; nothing on m_*.
- drop_count saturates at all-ones.
- A runt and a reject on the same cycle are impossible: runt takes priority.

Optional Feature:
Macro ETH_HDR_VLAN_EN.
- Defined: if the first type pair == 16'h8100, capture TCI into hdr_vlan_id[11:0] from the next 2 bytes. Then parse 2 more bytes as the real EtherType (state VLAN, 4 bytes total). Filtering uses the inner type. tlast within VLAN bytes counts as a runt.
- Not defined: 8100 is treated as an ordinary EtherType; hdr_vlan_id is tied to 0.

Decomposition:
- Package eth_pkg: ETH_BCAST_MAC, ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV4=16'h0800, ETH_TYPE_VLAN=16'h8100, ETH_MAC_LEN=6, parser state enum.
- One sub-module, eth_type_match: combinational priority match of the type table, producing hit and index.

Test Plan:
- local_mac=02:00:00:00:00:01, table={0800,0806} enabled. Unicast frame to local MAC, type 0800, 4 payload bytes AA BB CC DD (tlast on DD) -> hdr_valid once, hdr_type_idx=0, m_* carries AA..DD with m_tlast on DD, drop_count=0.
- Broadcast dst, type 0806 -> accepted, idx=1. Same frame to 02:00:00:00:00:02 with promisc_en=0 -> dropped, no m_tvalid, drop_count=1.
- Type 86DD, and type 0806 with type_enable=2'b01 -> both dropped, drop_count+2. Multicast 01:00:5E:00:00:01 with mcast_en=1 -> accepted.
- tlast on src byte 3 -> err_runt pulse, drop_count+1. Next valid frame parsed correctly.
- m_tready toggled 50% through a 64-byte payload -> no byte lost or duplicated, s_tready back-pressured. Reset asserted mid-payload -> SYNC; next frame after tlast accepted.
- ETH_HDR_VLAN_EN: frame with 8100, TCI 0x2064, inner type 0800 -> hdr_vlan_id=0x064, hdr_type=0800, accepted.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and parser state encoding for the Ethernet II RX header parser.
package eth_pkg;

  localparam int          ETH_MAC_LEN   = 6;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_DST,
    ST_SRC,
    ST_TYPE,
    ST_VLAN,
    ST_PAYLOAD,
    ST_DROP
  } eth_state_e;

endpackage

// File: rtl/eth_type_match.sv
// Combinational priority match of an EtherType against a programmable table.
// Ports:
//   type_in   : EtherType under test
//   tbl       : NUM_TYPES entries, entry i at [16*i+15 -: 16]
//   en        : per-entry enable
//   hit       : some enabled entry matches
//   idx       : lowest matching entry index (0 when no hit)
module eth_type_match #(
  parameter int NUM_TYPES = 2,
  parameter int IDX_W     = 1
) (
  input  logic [15:0]             type_in,
  input  logic [16*NUM_TYPES-1:0] tbl,
  input  logic [NUM_TYPES-1:0]    en,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx
);

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (en[i] && (tbl[16*i +: 16] == type_in)) begin
        hit = 1'b1;
        idx = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/eth_header_parser.sv
// Ethernet II RX header parser. Consumes an 8-bit AXI-Stream frame starting at
// the destination MAC MSB, captures dst/src MAC and EtherType, filters on dst
// MAC and an EtherType table, publishes a header record and forwards the
// payload of accepted frames through a single output register.
// Optional build macro ETH_HDR_VLAN_EN: parse one 802.1Q tag (TCI + inner type).
// Ports:
//   aclk/aresetn        : clock, synchronous active-low reset
//   s_t*                : input byte stream
//   m_t*                : payload byte stream (latency 1)
//   local_mac, type_table, type_enable, promisc_en, mcast_en : filter config
//   hdr_*               : header record, valid on hdr_valid pulse, held after
//   err_runt            : pulse when tlast lands inside the header
//   drop_count          : saturating count of rejected and runt frames
module eth_header_parser
  import eth_pkg::*;
#(
  parameter  int NUM_TYPES = 2,
  parameter  int CNT_W     = 16,
  localparam int IDX_W     = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [7:0]              m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  input  logic [47:0]             local_mac,
  input  logic [16*NUM_TYPES-1:0] type_table,
  input  logic [NUM_TYPES-1:0]    type_enable,
  input  logic                    promisc_en,
  input  logic                    mcast_en,
  output logic                    hdr_valid,
  output logic [47:0]             hdr_dst_mac,
  output logic [47:0]             hdr_src_mac,
  output logic [15:0]             hdr_type,
  output logic [IDX_W-1:0]        hdr_type_idx,
  output logic [11:0]             hdr_vlan_id,
  output logic                    err_runt,
  output logic [CNT_W-1:0]        drop_count
);

  localparam logic [2:0] MAC_LAST = 3'(ETH_MAC_LEN - 1);

  eth_state_e state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [47:0] dst_sh, src_sh;
  logic [15:0] type_sh, type_cur;
  logic        xfer, runt, decide, accept, reject, mac_ok, hit;
  logic [IDX_W-1:0] idx;

  // The output register only blocks in IDLE (so a new frame cannot start while
  // the previous last byte is stalled) and in PAYLOAD; header bytes are never
  // forwarded, so the other states always accept.
  assign s_tready = (state == ST_IDLE || state == ST_PAYLOAD) ? (!m_tvalid || m_tready) : 1'b1;
  assign xfer     = s_tvalid && s_tready;
  assign type_cur = {type_sh[7:0], s_tdata};

  assign mac_ok = promisc_en || (dst_sh == local_mac) || (dst_sh == ETH_BCAST_MAC) ||
                  (mcast_en && dst_sh[40]);

  eth_type_match #(.NUM_TYPES(NUM_TYPES), .IDX_W(IDX_W)) u_match (
    .type_in (type_cur),
    .tbl     (type_table),
    .en      (type_enable),
    .hit     (hit),
    .idx     (idx)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    runt    = 1'b0;
    decide  = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    if (xfer) begin
      case (state)
        ST_SYNC: if (s_tlast) state_n = ST_IDLE;
        // IDLE consumes dst byte 0; DST then counts bytes 1..5.
        ST_IDLE:
          if (s_tlast) runt = 1'b1;
          else begin state_n = ST_DST; cnt_n = 3'd1; end
        ST_DST:
          if (s_tlast) runt = 1'b1;
          else if (cnt == MAC_LAST) begin state_n = ST_SRC; cnt_n = '0; end
          else cnt_n = cnt + 3'd1;
        ST_SRC:
          if (s_tlast) runt = 1'b1;
          else if (cnt == MAC_LAST) begin state_n = ST_TYPE; cnt_n = '0; end
          else cnt_n = cnt + 3'd1;
        ST_TYPE:
          if (s_tlast) runt = 1'b1;
          else if (cnt == 3'd0) cnt_n = 3'd1;
`ifdef ETH_HDR_VLAN_EN
          else if (type_cur == ETH_TYPE_VLAN) begin state_n = ST_VLAN; cnt_n = '0; end
`endif
          else decide = 1'b1;
`ifdef ETH_HDR_VLAN_EN
        // Bytes 0-1: TCI, bytes 2-3: inner EtherType.
        ST_VLAN:
          if (s_tlast) runt = 1'b1;
          else if (cnt == 3'd3) decide = 1'b1;
          else cnt_n = cnt + 3'd1;
`endif
        ST_PAYLOAD, ST_DROP: if (s_tlast) state_n = ST_IDLE;
        default: state_n = ST_SYNC;
      endcase
      if (runt) begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      if (decide) begin
        cnt_n = '0;
        if (mac_ok && hit) begin accept = 1'b1; state_n = ST_PAYLOAD; end
        else               begin reject = 1'b1; state_n = ST_DROP;    end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dst_sh       <= '0;
      src_sh       <= '0;
      type_sh      <= '0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      hdr_valid    <= 1'b0;
      hdr_dst_mac  <= '0;
      hdr_src_mac  <= '0;
      hdr_type     <= '0;
      hdr_type_idx <= '0;
      err_runt     <= 1'b0;
      drop_count   <= '0;
    end else begin
      hdr_valid <= accept;
      err_runt  <= runt;
      if (xfer) begin
        case (state)
          ST_IDLE, ST_DST: dst_sh  <= {dst_sh[39:0], s_tdata};
          ST_SRC:          src_sh  <= {src_sh[39:0], s_tdata};
          ST_TYPE:         type_sh <= {type_sh[7:0], s_tdata};
          ST_VLAN:         if (cnt[1]) type_sh <= {type_sh[7:0], s_tdata};
          default: ;
        endcase
      end
      if (accept) begin
        hdr_dst_mac  <= dst_sh;
        hdr_src_mac  <= src_sh;
        hdr_type     <= type_cur;
        hdr_type_idx <= idx;
      end
      if ((runt || reject) && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
      if (state == ST_PAYLOAD && xfer) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_tdata;
        m_tlast  <= s_tlast;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

`ifdef ETH_HDR_VLAN_EN
  logic [15:0] tci_sh;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tci_sh      <= '0;
      hdr_vlan_id <= '0;
    end else begin
      if (xfer && state == ST_VLAN && !cnt[1]) tci_sh <= {tci_sh[7:0], s_tdata};
      // Untagged frames report VLAN 0.
      if (accept) hdr_vlan_id <= (state == ST_VLAN) ? tci_sh[11:0] : 12'h000;
    end
  end
`else
  assign hdr_vlan_id = 12'h000;
`endif

endmodule

// File: tb/tb_eth_header_parser.sv
module tb_eth_header_parser;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready;
  logic [47:0] local_mac;
  logic [31:0] type_table;
  logic [1:0]  type_enable;
  logic        promisc_en, mcast_en;
  logic        hdr_valid;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_type;
  logic [0:0]  hdr_type_idx;
  logic [11:0] hdr_vlan_id;
  logic        err_runt;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  // monitor state
  logic [8:0] out_q[$];
  int hv_cnt = 0, er_cnt = 0, stall_cnt = 0;
  logic toggle_en = 1'b0;
  logic [7:0] pl[$];

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SMAC = 48'h00_11_22_33_44_55;

  eth_header_parser #(.NUM_TYPES(2), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .local_mac(local_mac), .type_table(type_table), .type_enable(type_enable),
    .promisc_en(promisc_en), .mcast_en(mcast_en),
    .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_type(hdr_type), .hdr_type_idx(hdr_type_idx), .hdr_vlan_id(hdr_vlan_id),
    .err_runt(err_runt), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (toggle_en) m_tready = ~m_tready;

  // Sample mid-cycle, after all negedge-driven inputs have settled.
  always @(negedge aclk) begin
    #2;
    if (m_tvalid === 1'b1 && m_tready === 1'b1) out_q.push_back({m_tlast, m_tdata});
    if (hdr_valid === 1'b1) hv_cnt++;
    if (err_runt === 1'b1) er_cnt++;
    if (s_tvalid === 1'b1 && s_tready === 1'b0) stall_cnt++;
  end

  // Called at a negedge; returns at a negedge after the byte is transferred.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    logic rdy;
    n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    do begin
      #1 rdy = s_tready;
      @(posedge aclk);
      @(negedge aclk);
      n++;
    end while (!rdy && n < 300);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%02h s_tready stayed low", d);
    end
  endtask

  // runt_at: header byte index carrying tlast (-1 none); stop_at: payload bytes
  // to send before abandoning the frame without tlast (-1 = whole payload).
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                            input int runt_at, input int stop_at);
    logic [111:0] h;
    h = {dst, SMAC, typ};
    for (int i = 0; i < 14; i++) begin
      send_byte(h[111-8*i -: 8], i == runt_at);
      if (i == runt_at) return;
    end
    for (int i = 0; i < pl.size(); i++) begin
      if (stop_at >= 0 && i >= stop_at) return;
      send_byte(pl[i], i == pl.size() - 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_tvalid === 1'b1 && n < 300) begin @(negedge aclk); n++; end
    repeat (3) @(negedge aclk);
  endtask

  task automatic clr();
    out_q.delete(); hv_cnt = 0; er_cnt = 0; stall_cnt = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0 || hdr_valid !== 1'b0 || err_runt !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", m_tvalid, hdr_valid, err_runt); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if (hdr_dst_mac !== 48'd0 || hdr_type !== 16'd0 || hdr_vlan_id !== 12'd0) begin failures++; $display("FAIL reset_hdr dst=%h type=%h vid=%h exp=0", hdr_dst_mac, hdr_type, hdr_vlan_id); end
    aresetn = 1'b1;
    @(negedge aclk);
    send_byte(8'h00, 1'b1);  // SYNC realignment
    clr();
  endtask

  task automatic test_unicast();
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clr();
    send_frame(LMAC, 16'h0800, -1, -1);
    drain();
    checks++; if (hv_cnt !== 1) begin failures++; $display("FAIL uni_hdr_valid got=%0d exp=1", hv_cnt); end
    checks++; if (hdr_type_idx !== 1'b0 || hdr_type !== 16'h0800) begin failures++; $display("FAIL uni_type idx=%0d type=%h exp=0/0800", hdr_type_idx, hdr_type); end
    checks++; if (hdr_dst_mac !== LMAC || hdr_src_mac !== SMAC) begin failures++; $display("FAIL uni_macs dst=%h src=%h", hdr_dst_mac, hdr_src_mac); end
    checks++; if (out_q.size() !== 4) begin failures++; $display("FAIL uni_len got=%0d exp=4", out_q.size()); end
    else begin
      checks++; if (out_q[0] !== 9'h0AA || out_q[1] !== 9'h0BB || out_q[2] !== 9'h0CC || out_q[3] !== 9'h1DD)
        begin failures++; $display("FAIL uni_data got=%h %h %h %h exp=0aa 0bb 0cc 1dd", out_q[0], out_q[1], out_q[2], out_q[3]); end
    end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL uni_drop got=%0d exp=0", drop_count); end
    checks++; if (hdr_vlan_id !== 12'd0) begin failures++; $display("FAIL uni_vid got=%h exp=0", hdr_vlan_id); end
  endtask

  task automatic test_bcast_and_miss();
    pl = '{8'h01, 8'h02};
    clr();
    send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, -1, -1);
    drain();
    checks++; if (hv_cnt !== 1 || hdr_type_idx !== 1'b1) begin failures++; $display("FAIL bcast_accept hv=%0d idx=%0d exp=1/1", hv_cnt, hdr_type_idx); end
    checks++; if (out_q.size() !== 2) begin failures++; $display("FAIL bcast_len got=%0d exp=2", out_q.size()); end
    clr();
    send_frame(48'h02_00_00_00_00_02, 16'h0806, -1, -1);
    drain();
    checks++; if (hv_cnt !== 0 || out_q.size() !== 0) begin failures++; $display("FAIL miss_drop hv=%0d out=%0d exp=0/0", hv_cnt, out_q.size()); end
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL miss_count got=%0d exp=1", drop_count); end
    checks++; if (hdr_dst_mac !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL miss_hold dst=%h exp=ffffffffffff", hdr_dst_mac); end
  endtask

  task automatic test_filters();
    pl = '{8'h55};
    clr();
    send_frame(LMAC, 16'h86DD, -1, -1);
    type_enable = 2'b01;
    send_frame(LMAC, 16'h0806, -1, -1);
    drain();
    type_enable = 2'b11;
    checks++; if (hv_cnt !== 0 || out_q.size() !== 0 || drop_count !== 16'd3) begin failures++; $display("FAIL type_reject hv=%0d out=%0d drop=%0d exp=0/0/3", hv_cnt, out_q.size(), drop_count); end
    clr();
    mcast_en = 1'b1;
    send_frame(48'h01_00_5E_00_00_01, 16'h0800, -1, -1);
    drain();
    mcast_en = 1'b0;
    checks++; if (hv_cnt !== 1 || hdr_dst_mac !== 48'h01_00_5E_00_00_01 || out_q.size() !== 1) begin failures++; $display("FAIL mcast_accept hv=%0d dst=%h out=%0d", hv_cnt, hdr_dst_mac, out_q.size()); end
    clr();
    promisc_en = 1'b1;
    send_frame(48'h02_00_00_00_00_09, 16'h0806, -1, -1);
    drain();
    promisc_en = 1'b0;
    checks++; if (hv_cnt !== 1 || hdr_type_idx !== 1'b1 || drop_count !== 16'd3) begin failures++; $display("FAIL promisc_accept hv=%0d idx=%0d drop=%0d exp=1/1/3", hv_cnt, hdr_type_idx, drop_count); end
  endtask

  task automatic test_runt();
    pl = '{8'h10, 8'h20, 8'h30};
    clr();
    send_frame(LMAC, 16'h0800, 9, -1);  // tlast on src byte 3
    drain();
    checks++; if (er_cnt !== 1 || hv_cnt !== 0 || drop_count !== 16'd4) begin failures++; $display("FAIL runt_src er=%0d hv=%0d drop=%0d exp=1/0/4", er_cnt, hv_cnt, drop_count); end
    clr();
    send_frame(LMAC, 16'h0800, 13, -1); // tlast on 2nd type byte
    drain();
    checks++; if (er_cnt !== 1 || hv_cnt !== 0 || out_q.size() !== 0 || drop_count !== 16'd5) begin failures++; $display("FAIL runt_type er=%0d hv=%0d out=%0d drop=%0d exp=1/0/0/5", er_cnt, hv_cnt, out_q.size(), drop_count); end
    clr();
    send_frame(LMAC, 16'h0806, -1, -1);
    drain();
    checks++; if (hv_cnt !== 1 || hdr_type !== 16'h0806 || out_q.size() !== 3 || er_cnt !== 0) begin failures++; $display("FAIL runt_recover hv=%0d type=%h out=%0d er=%0d", hv_cnt, hdr_type, out_q.size(), er_cnt); end
    else begin
      checks++; if (out_q[2] !== 9'h130) begin failures++; $display("FAIL runt_recover_last got=%h exp=130", out_q[2]); end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 3 + 1));
    clr();
    toggle_en = 1'b1;
    send_frame(LMAC, 16'h0800, -1, -1);
    toggle_en = 1'b0;
    m_tready = 1'b1;
    drain();
    checks++; if (out_q.size() !== 64) begin failures++; $display("FAIL bp_len got=%0d exp=64", out_q.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (out_q[i] !== {(i == 63) ? 1'b1 : 1'b0, 8'(i * 3 + 1)}) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_data bad_bytes=%0d exp=0", bad); end
    end
    checks++; if (stall_cnt == 0) begin failures++; $display("FAIL bp_stall got=0 exp=>0"); end
  endtask

  task automatic test_idle_stall();
    pl = '{8'h77};
    clr();
    m_tready = 1'b0;
    send_frame(LMAC, 16'h0800, -1, -1);
    @(negedge aclk);
    s_tvalid = 1'b1; s_tdata = 8'h02;
    #1;
    checks++; if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin failures++; $display("FAIL idle_stall m_tvalid=%b s_tready=%b exp=1/0", m_tvalid, s_tready); end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    drain();
    checks++; if (out_q.size() !== 1 || out_q[0] !== 9'h177) begin failures++; $display("FAIL idle_stall_out n=%0d exp=1 byte 177", out_q.size()); end
  endtask

  task automatic test_mid_reset();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    clr();
    send_frame(LMAC, 16'h0800, -1, 3);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || drop_count !== 16'd0 || hdr_type !== 16'd0) begin failures++; $display("FAIL mid_reset m_tvalid=%b drop=%0d type=%h exp=0/0/0", m_tvalid, drop_count, hdr_type); end
    @(negedge aclk);
    clr();
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    pl = '{8'hE1, 8'hE2};
    send_frame(LMAC, 16'h0806, -1, -1);
    drain();
    checks++; if (hv_cnt !== 1 || hdr_type !== 16'h0806 || er_cnt !== 0 || drop_count !== 16'd0) begin failures++; $display("FAIL sync_recover hv=%0d type=%h er=%0d drop=%0d", hv_cnt, hdr_type, er_cnt, drop_count); end
    checks++; if (out_q.size() !== 2 || out_q[0] !== 9'h0E1 || out_q[1] !== 9'h1E2) begin failures++; $display("FAIL sync_recover_data n=%0d exp=2 (0e1 1e2)", out_q.size()); end
  endtask

  task automatic test_vlan();
    pl = '{8'h20, 8'h64, 8'h08, 8'h00, 8'h11};
    clr();
    send_frame(LMAC, 16'h8100, -1, -1);
    drain();
`ifdef ETH_HDR_VLAN_EN
    checks++; if (hv_cnt !== 1 || hdr_vlan_id !== 12'h064 || hdr_type !== 16'h0800) begin failures++; $display("FAIL vlan_accept hv=%0d vid=%h type=%h exp=1/064/0800", hv_cnt, hdr_vlan_id, hdr_type); end
    checks++; if (out_q.size() !== 1 || out_q[0] !== 9'h111) begin failures++; $display("FAIL vlan_payload n=%0d exp=1 byte 111", out_q.size()); end
`else
    checks++; if (hv_cnt !== 0 || out_q.size() !== 0 || drop_count !== 16'd1 || hdr_vlan_id !== 12'd0) begin failures++; $display("FAIL vlan_off hv=%0d out=%0d drop=%0d vid=%h exp=0/0/1/0", hv_cnt, out_q.size(), drop_count, hdr_vlan_id); end
`endif
  endtask

  initial begin
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    local_mac = LMAC; type_table = {16'h0806, 16'h0800}; type_enable = 2'b11;
    promisc_en = 1'b0; mcast_en = 1'b0; aresetn = 1'b0;
    @(negedge aclk);
    test_reset();
    test_unicast();
    test_bcast_and_miss();
    test_filters();
    test_runt();
    test_backpressure();
    test_idle_stall();
    test_mid_reset();
    test_vlan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
